// File: rtl/micro_sequencer.sv
// Microprogram sequencer: writable control store, microprogram counter, UIR,
// next-address logic with a return stack, and a sticky stack-error flag.
module micro_sequencer #(
    parameter int ADDR_W      = 4,
    parameter int CTRL_W      = 12,
    parameter int NCOND       = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic                                         start,
    input  logic                                         stall,
    input  logic [NCOND-1:0]                             cond,
    input  logic [ADDR_W-1:0]                            dispatch_addr,
    input  logic                                         prog_we,
    input  logic [ADDR_W-1:0]                            prog_addr,
    input  logic [CTRL_W+3+((NCOND>1)?$clog2(NCOND):1)+ADDR_W-1:0] prog_data,
    output logic [CTRL_W-1:0]                            ctrl_out,
    output logic [ADDR_W-1:0]                            mpc_out,
    output logic                                         running,
    output logic                                         halted,
    output logic                                         error
);

    localparam int CSEL_W = (NCOND > 1) ? $clog2(NCOND) : 1;
    localparam int WORD_W = CTRL_W + 3 + CSEL_W + ADDR_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int SP_W   = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_INC      = 3'b000,
        OP_JMP      = 3'b001,
        OP_JT       = 3'b010,
        OP_JF       = 3'b011,
        OP_CALL     = 3'b100,
        OP_RET      = 3'b101,
        OP_DISPATCH = 3'b110,
        OP_HALT     = 3'b111
    } op_e;

    logic [WORD_W-1:0] store_q [DEPTH];
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] mpc_q, mpc_d;
    logic [WORD_W-1:0] uir_q, uir_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] f_addr;
    logic [CSEL_W-1:0] f_csel;
    op_e               f_op;
    logic [ADDR_W-1:0] mpc_inc;
    logic [ADDR_W-1:0] next_addr;
    logic              cond_bit;
    logic              stack_full;
    logic              stack_empty;
    logic              push_en;
    logic              write_en;

    assign f_addr      = uir_q[ADDR_W-1:0];
    assign f_csel      = uir_q[ADDR_W +: CSEL_W];
    assign f_op        = op_e'(uir_q[ADDR_W+CSEL_W +: 3]);
    assign mpc_inc     = mpc_q + ADDR_W'(1);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);

    // Writes are accepted only outside RUN, and a same-cycle start wins.
    assign write_en = prog_we && (state_q != RUN) && !start;

    // Out-of-range condition selects fall back to condition 0.
    always_comb begin
        cond_bit = cond[0];
        for (int i = 0; i < NCOND; i++) begin
            if (f_csel == CSEL_W'(i)) cond_bit = cond[i];
        end
    end

    always_comb begin
        next_addr = mpc_inc;
        unique case (f_op)
            OP_JMP, OP_CALL: next_addr = f_addr;
            OP_JT:           next_addr = cond_bit ? f_addr : mpc_inc;
            OP_JF:           next_addr = cond_bit ? mpc_inc : f_addr;
            OP_RET:          next_addr = stack_q[IDX_W'(sp_q - SP_W'(1))];
            OP_DISPATCH:     next_addr = dispatch_addr;
            default:         next_addr = mpc_inc;
        endcase
    end

    // NOTE: every signal driven here gets a default first so no latches are inferred.
    always_comb begin
        state_d = state_q;
        mpc_d   = mpc_q;
        uir_d   = uir_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push_en = 1'b0;
        unique case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    state_d = RUN;
                    mpc_d   = '0;
                    uir_d   = store_q[0];
                    sp_d    = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (f_op == OP_HALT) begin
                        state_d = HALTED;
                    end else if (f_op == OP_CALL && stack_full) begin
                        err_d   = 1'b1;
                        state_d = HALTED;
                    end else if (f_op == OP_RET && stack_empty) begin
                        err_d   = 1'b1;
                        state_d = HALTED;
                    end else begin
                        if (f_op == OP_CALL) begin
                            push_en = 1'b1;
                            sp_d    = sp_q + SP_W'(1);
                        end else if (f_op == OP_RET) begin
                            sp_d = sp_q - SP_W'(1);
                        end
                        mpc_d = next_addr;
                        uir_d = store_q[next_addr];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            mpc_q   <= '0;
            uir_q   <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mpc_q   <= mpc_d;
            uir_q   <= uir_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    // NOTE: control store and stack entries are deliberately not reset; the store
    // survives reset and the stack pointer alone defines which entries are valid.
    always_ff @(posedge clock) begin
        if (write_en) store_q[prog_addr] <= prog_data;
        if (push_en) stack_q[IDX_W'(sp_q)] <= mpc_inc;
    end

    assign ctrl_out = (state_q == RUN) ? uir_q[WORD_W-1 -: CTRL_W] : '0;
    assign mpc_out  = mpc_q;
    assign running  = (state_q == RUN);
    assign halted   = (state_q == HALTED);
    assign error    = err_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: one default instance plus a
// STACK_DEPTH=1 instance sharing the same stimulus for the overflow case.
module tb_micro_sequencer;

    localparam int ADDR_W = 4;
    localparam int CTRL_W = 12;
    localparam int NCOND  = 4;
    localparam int WORD_W = CTRL_W + 3 + 2 + ADDR_W;

    localparam logic [2:0] OP_INC = 3'b000, OP_JT = 3'b010,
                           OP_CALL = 3'b100, OP_RET = 3'b101, OP_DISPATCH = 3'b110,
                           OP_HALT = 3'b111;

    logic              clock;
    logic              reset;
    logic              start;
    logic              stall;
    logic [NCOND-1:0]  cond;
    logic [ADDR_W-1:0] dispatch_addr;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [WORD_W-1:0] prog_data;

    logic [CTRL_W-1:0] ctrl_out, ctrl_out1;
    logic [ADDR_W-1:0] mpc_out, mpc_out1;
    logic              running, running1;
    logic              halted, halted1;
    logic              error, error1;

    int n_checks = 0;
    int n_fail   = 0;

    micro_sequencer u_dut (
        .clock(clock), .reset(reset), .start(start), .stall(stall), .cond(cond),
        .dispatch_addr(dispatch_addr), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .ctrl_out(ctrl_out), .mpc_out(mpc_out),
        .running(running), .halted(halted), .error(error)
    );

    micro_sequencer #(.STACK_DEPTH(1)) u_dut1 (
        .clock(clock), .reset(reset), .start(start), .stall(stall), .cond(cond),
        .dispatch_addr(dispatch_addr), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .ctrl_out(ctrl_out1), .mpc_out(mpc_out1),
        .running(running1), .halted(halted1), .error(error1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [WORD_W-1:0] mw(input logic [2:0] op, input logic [1:0] csel,
                                             input logic [3:0] addr, input logic [11:0] ctrl);
        return {ctrl, op, csel, addr};
    endfunction

    task automatic prog(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; cond = '0; dispatch_addr = '0;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_ctrl", ctrl_out, 0);
        check("rst_mpc", mpc_out, 0);
        check("rst_running", running, 0);
        check("rst_halted", halted, 0);
        check("rst_error", error, 0);

        // Linear run
        prog(0, mw(OP_INC, 0, 0, 12'h001));
        prog(1, mw(OP_INC, 0, 0, 12'h002));
        prog(2, mw(OP_HALT, 0, 0, 12'h004));
        pulse_start();
        check("lin_run", running, 1);
        check("lin_c0", ctrl_out, 12'h001);
        tick();
        check("lin_c1", ctrl_out, 12'h002);
        tick();
        check("lin_c2", ctrl_out, 12'h004);
        tick();
        check("lin_halted", halted, 1);
        check("lin_ctrl0", ctrl_out, 0);
        check("lin_mpc", mpc_out, 2);

        // Conditional branch, taken then not taken
        prog(0, mw(OP_JT, 2, 5, 12'h010));
        prog(1, mw(OP_HALT, 0, 0, 12'h011));
        prog(5, mw(OP_HALT, 0, 0, 12'h015));
        cond = 4'b0100;
        pulse_start();
        check("jt_m0", mpc_out, 0);
        tick();
        check("jt_m5", mpc_out, 5);
        check("jt_c5", ctrl_out, 12'h015);
        tick();
        check("jt_halt", halted, 1);
        cond = 4'b0000;
        pulse_start();
        check("jf_m0", mpc_out, 0);
        tick();
        check("jf_m1", mpc_out, 1);
        tick();
        check("jf_halt", halted, 1);

        // Call / return
        prog(0, mw(OP_CALL, 0, 8, 12'h020));
        prog(8, mw(OP_RET, 0, 0, 12'h028));
        pulse_start();
        check("cr_m0", mpc_out, 0);
        tick();
        check("cr_m8", mpc_out, 8);
        tick();
        check("cr_m1", mpc_out, 1);
        tick();
        check("cr_halt", halted, 1);
        check("cr_err", error, 0);

        // Dispatch with a 3-cycle stall
        prog(0, mw(OP_DISPATCH, 0, 0, 12'h0A5));
        prog(12, mw(OP_HALT, 0, 0, 12'h0CC));
        dispatch_addr = 4'hC;
        pulse_start();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_mpc", mpc_out, 0);
            check("st_ctrl", ctrl_out, 12'h0A5);
        end
        stall = 1'b0;
        tick();
        check("ds_mpc", mpc_out, 4'hC);
        check("ds_ctrl", ctrl_out, 12'h0CC);
        tick();
        check("ds_halt", halted, 1);

        // Wrap, then RET on empty stack
        prog(0, mw(OP_DISPATCH, 0, 0, 12'h0D0));
        prog(15, mw(OP_INC, 0, 0, 12'h0F0));
        prog(3, mw(OP_RET, 0, 0, 12'h033));
        dispatch_addr = 4'hF;
        pulse_start();
        tick();
        check("wr_m15", mpc_out, 15);
        check("wr_c15", ctrl_out, 12'h0F0);
        tick();
        check("wr_m0", mpc_out, 0);
        dispatch_addr = 4'h3;
        tick();
        check("ue_m3", mpc_out, 3);
        tick();
        check("ue_err", error, 1);
        check("ue_halt", halted, 1);
        check("ue_mpc", mpc_out, 3);
        dispatch_addr = 4'hF;
        pulse_start();
        check("ue_restart_run", running, 1);
        check("ue_restart_mpc", mpc_out, 0);
        check("ue_sticky", error, 1);

        // Reset mid-run keeps the store
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rr_running", running, 0);
        check("rr_ctrl", ctrl_out, 0);
        check("rr_mpc", mpc_out, 0);
        check("rr_err", error, 0);
        pulse_start();
        check("rr_keep0", ctrl_out, 12'h0D0);
        tick();
        check("rr_keep15", ctrl_out, 12'h0F0);

        // Write during RUN is ignored
        prog(15, mw(OP_HALT, 0, 0, 12'hBAD));
        check("wrun_running", running, 1);
        do_reset();
        pulse_start();
        tick();
        check("wrun_mpc", mpc_out, 15);
        check("wrun_ctrl", ctrl_out, 12'h0F0);

        // start and prog_we in the same IDLE cycle: write dropped
        do_reset();
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'hF;
        prog_data = mw(OP_HALT, 0, 0, 12'hBAD);
        tick();
        start   = 1'b0;
        prog_we = 1'b0;
        check("sw_mpc", mpc_out, 0);
        tick();
        check("sw_ctrl", ctrl_out, 12'h0F0);

        // Stack overflow on the STACK_DEPTH=1 instance
        do_reset();
        prog(0, mw(OP_CALL, 0, 8, 12'h040));
        prog(8, mw(OP_CALL, 0, 8, 12'h048));
        pulse_start();
        check("ov_m0", mpc_out1, 0);
        tick();
        check("ov_m8", mpc_out1, 8);
        check("ov_err0", error1, 0);
        check("ov_halt0", halted1, 0);
        tick();
        check("ov_halt", halted1, 1);
        check("ov_err", error1, 1);
        check("ov_mpc", mpc_out1, 8);
        check("ov_deep_run", running, 1);
        check("ov_deep_err", error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
